// File: rtl/axis_frame_gen_if.sv
// AXI-Stream byte/word channel shared between the frame source and its sink.
// The master drives data, valid and last, and the slave drives ready.
interface axis_frame_gen_if #(
   parameter int unsigned DW = 8
);
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame source: programmable frame count, length and inter-frame gap,
// incrementing pattern (seed + frame + beat), with backpressure and sticky abort.
module axis_frame_gen #(
   parameter int unsigned DW    = 8,
   parameter int unsigned LEN_W = 13,
   parameter int unsigned CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [LEN_W-1:0]     frame_len,
   input  logic [CNT_W-1:0]     num_frames,
   input  logic [7:0]           gap_cycles,
   input  logic [DW-1:0]        seed,
   axis_frame_gen_if.master     m,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_W-1:0]     frame_cnt
);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e             state_q, state_d;
   logic [LEN_W-1:0]   len_q, len_d, k_q, k_d;
   logic [CNT_W-1:0]   num_q, num_d, cnt_q, cnt_d, cnt_inc;
   logic [7:0]         gap_q, gap_d, gap_cnt_q, gap_cnt_d;
   logic [DW-1:0]      seed_q, seed_d, f_q, f_d, tdata_q, tdata_d;
   logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
   logic               busy_q, busy_d, done_q, done_d, abort_q, abort_d;
   logic               fire, stop_req, end_run;

   assign fire     = tvalid_q && m.tready;
   assign stop_req = abort_q || abort;
   assign cnt_inc  = cnt_q + CNT_W'(1);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      k_d       = k_q;
      num_d     = num_q;
      cnt_d     = cnt_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      seed_d    = seed_q;
      f_d       = f_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tlast_d   = tlast_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      abort_d   = abort_q || (abort && state_q != StIdle);
      end_run   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start && frame_len != '0) begin
               len_d    = frame_len;
               num_d    = num_frames;
               gap_d    = gap_cycles;
               seed_d   = seed;
               cnt_d    = '0;
               k_d      = '0;
               f_d      = '0;
               tdata_d  = seed;
               tlast_d  = (frame_len == LEN_W'(1));
               tvalid_d = 1'b1;
               busy_d   = 1'b1;
               state_d  = StSend;
            end
         end
         StSend: begin
            if (fire) begin
               if (tlast_q) begin
                  cnt_d = cnt_inc;
                  f_d   = f_q + DW'(1);
                  k_d   = '0;
                  if ((num_q != '0 && cnt_inc == num_q) || stop_req) begin
                     end_run = 1'b1;
                  end else if (gap_q == 8'd0) begin
                     tdata_d = seed_q + f_q + DW'(1);
                     tlast_d = (len_q == LEN_W'(1));
                  end else begin
                     // Counts down to zero, so GAP lasts exactly gap_q cycles.
                     gap_cnt_d = gap_q - 8'd1;
                     tvalid_d  = 1'b0;
                     tlast_d   = 1'b0;
                     state_d   = StGap;
                  end
               end else begin
                  k_d     = k_q + LEN_W'(1);
                  tdata_d = tdata_q + DW'(1);
                  tlast_d = (k_q + LEN_W'(1) == len_q - LEN_W'(1));
               end
            end
         end
         StGap: begin
            if (stop_req) begin
               end_run = 1'b1;
            end else if (gap_cnt_q == 8'd0) begin
               tdata_d  = seed_q + f_q;
               tlast_d  = (len_q == LEN_W'(1));
               tvalid_d = 1'b1;
               state_d  = StSend;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (end_run) begin
         state_d  = StIdle;
         tvalid_d = 1'b0;
         tlast_d  = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b1;
         abort_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         k_q       <= '0;
         num_q     <= '0;
         cnt_q     <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         seed_q    <= '0;
         f_q       <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         tlast_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         k_q       <= k_d;
         num_q     <= num_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         seed_q    <= seed_d;
         f_q       <= f_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         tlast_q   <= tlast_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   assign m.tdata   = tdata_q;
   assign m.tvalid  = tvalid_q;
   assign m.tlast   = tlast_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_cnt = cnt_q;

endmodule
